ball_mover: RTL and testbench
=============================

# ball_mover

Ball motion controller for the four-paddle pong playfield. It owns the ball position and direction and advances the ball one cell diagonally every `TICK_DIV` clocks. It consumes the registered `{x_collide, y_collide}` flags from the paddle collision detector, which it drives with `pos`. A ball that reaches any border cell is a miss: the block reports the side and re-centres the ball.

## Interface
- `WIDTH`, 16: playfield cells per axis; coordinates run 0..WIDTH-1.
- `BIT_OF_WIDTH`, 4: bits per coordinate; log2(WIDTH).
- `TICK_DIV`, 4: clocks per ball step; must be ≥2 so the detector's one-cycle latency settles.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  serve request; honoured only in IDLE.
- `serve_dir`  in  2  initial direction {dir_x, dir_y}; 1 = increasing coordinate.
- `pause`  in  1  freezes the tick counter and all state while high.
- `collide`  in  2  {x_collide, y_collide} from the collision detector.
- `pos`  out  2*BIT_OF_WIDTH  ball position; x in `pos[2*BIT_OF_WIDTH-1:BIT_OF_WIDTH]`, y in `pos[BIT_OF_WIDTH-1:0]`.
- `dir`  out  2  current {dir_x, dir_y}.
- `step`  out  1  one-cycle pulse in the cycle after `pos` changes due to a move.
- `miss_side`  out  4  {top, down, left, right}; non-zero only in SCORE.
- `running`  out  1  high in RUN.

## Operation
- Centre is C = WIDTH/2-1 on both axes (7,7 for WIDTH=16).
- Sides map to cells as follows: top is y=0, down is y=WIDTH-1, left is x=0, right is x=WIDTH-1.
- States are IDLE, RUN and SCORE.
- **IDLE:**
  - `pos` = {C,C}, tick counter 0.
  - `start`=1 loads `dir` <= `serve_dir` and moves to RUN.
- **RUN:**
  - The tick counter increments on every clock with `pause`=0.
  - When counter == TICK_DIV-1 and `pause`=0, a step occurs at that edge and the counter returns to 0.
- **Step:**
  - Sample `collide`.
  - `collide[0]` (y_collide, left/right paddle) inverts dir_x.
  - `collide[1]` (x_collide, top/down paddle) inverts dir_y.
  - If both are set, both invert (corner hit).
  - The new position uses the updated direction on each axis: +1 if dir=1, else -1, computed in BIT_OF_WIDTH-bit arithmetic.
  - If the new x or y is 0 or WIDTH-1, `pos` takes that border value, `miss_side` is loaded with every border touched, and the state goes to SCORE.
  - Otherwise the state stays in RUN.
- **SCORE:**
  - Lasts exactly one cycle; `pos` holds the border cell.
  - Next edge: IDLE, `pos` = {C,C}, `miss_side` = 0, `dir` held.
- `start` in RUN or SCORE is ignored.
- `pause` in IDLE or SCORE has no effect.
- `collide` is ignored outside step edges.

## Timing
- Reset values: `pos`={C,C}, `dir`=2'b00, `step`=0, `miss_side`=4'b0000, `running`=0, state IDLE, counter 0.
- Reset has priority over every other input, including mid-step and mid-SCORE.
- `start` sampled high at edge N in IDLE gives `running`=1 from N+1.
- The first `pos` change occurs at edge N+TICK_DIV when unpaused.
- Move spacing is TICK_DIV unpaused clocks; each paused cycle adds one clock.
- `step` is registered and is high the cycle after the `pos` update; it is also pulsed on the step that enters SCORE.
- `pos` is stable for ≥TICK_DIV-1 cycles before the next sampling edge, which covers the detector's one-cycle registered latency.
- `miss_side` is valid for exactly the one SCORE cycle.
- `running` is low in SCORE.

## Test plan
- **Reset/idle:** Assert `rst` 2 cycles, then hold `start`=0 for 20 cycles. Required: `pos`=0x77, `dir`=00, `running`=0, `step` never pulses.
- **Free run to corner** (TICK_DIV=2): `start` with `serve_dir`=11 and `collide`=00.
  - `pos` must go 0x88, 0x99, … 0xEE, 0xFF, one step every 2 clocks.
  - At 0xFF: SCORE with `miss_side`=0101 for one cycle.
  - Then IDLE with `pos`=0x77.
- **Bounce:**
  - Serve 11 and hold `collide`=01 only on the step edge leaving 0x88. Required: `dir`=01, next `pos`=0x79.
  - Repeat with `collide`=11. Required: `dir`=00, `pos`=0x77.
- **Pause:** In RUN, assert `pause` for 5 cycles mid-count. Required: `pos`, `dir` and counter frozen; the next step arrives exactly 5 cycles late.
- **Start ignored / reset mid-run:**
  - Pulse `start` with `serve_dir`=00 during RUN. Required: `dir` unchanged.
  - Assert `rst` on a step edge. Required: next cycle `pos`=0x77, `dir`=00, `running`=0, no `step` pulse.
- **Miss left/top:** Serve 00 from centre with no collides. Required: reach 0x00 after 7 steps, `miss_side`=1010.

Source files
------------

// File: rtl/ball_mover.sv
// Ball motion controller for the four-paddle pong playfield: advances the ball
// one diagonal cell every TICK_DIV clocks, bounces on paddle hits, scores misses.
module ball_mover #(
  parameter int WIDTH        = 16,
  parameter int BIT_OF_WIDTH = 4,
  parameter int TICK_DIV     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [1:0]                serve_dir_i,
  input  logic                      pause_i,
  input  logic [1:0]                collide_i,
  output logic [2*BIT_OF_WIDTH-1:0] pos_o,
  output logic [1:0]                dir_o,
  output logic                      step_o,
  output logic [3:0]                miss_side_o,
  output logic                      running_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [BIT_OF_WIDTH-1:0] CENTRE   = BIT_OF_WIDTH'(WIDTH / 2 - 1);
  localparam logic [BIT_OF_WIDTH-1:0] EDGE_HI  = BIT_OF_WIDTH'(WIDTH - 1);
  localparam logic [CW-1:0]           CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCORE} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BIT_OF_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]              dir_q, dir_d;
  logic                    step_q, step_d;
  logic [3:0]              miss_q, miss_d;

  // Candidate move for this cycle; only committed on a step edge.
  logic [1:0]              dir_new;
  logic [BIT_OF_WIDTH-1:0] x_step, y_step;
  logic [3:0]              hit;

  // y_collide (left/right paddle) flips the x direction and vice versa.
  assign dir_new = dir_q ^ {collide_i[0], collide_i[1]};
  assign x_step  = dir_new[1] ? x_q + BIT_OF_WIDTH'(1) : x_q - BIT_OF_WIDTH'(1);
  assign y_step  = dir_new[0] ? y_q + BIT_OF_WIDTH'(1) : y_q - BIT_OF_WIDTH'(1);
  assign hit     = {y_step == '0, y_step == EDGE_HI, x_step == '0, x_step == EDGE_HI};

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    miss_d  = miss_q;
    unique case (state_q)
      S_IDLE: begin
        x_d    = CENTRE;
        y_d    = CENTRE;
        cnt_d  = '0;
        miss_d = '0;
        if (start_i) begin
          dir_d   = serve_dir_i;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!pause_i) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            dir_d  = dir_new;
            x_d    = x_step;
            y_d    = y_step;
            step_d = 1'b1;
            if (hit != 4'b0000) begin
              miss_d  = hit;
              state_d = S_SCORE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_SCORE: begin
        state_d = S_IDLE;
        x_d     = CENTRE;
        y_d     = CENTRE;
        cnt_d   = '0;
        miss_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= CENTRE;
      y_q     <= CENTRE;
      dir_q   <= 2'b00;
      step_q  <= 1'b0;
      miss_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      miss_q  <= miss_d;
    end
  end

  assign pos_o       = {x_q, y_q};
  assign dir_o       = dir_q;
  assign step_o      = step_q;
  assign miss_side_o = miss_q;
  assign running_o   = (state_q == S_RUN);

endmodule

// File: tb/tb_ball_mover.sv
// Self-checking bench for ball_mover: directed scenarios plus a randomized run
// compared cycle by cycle against a coordinate-level model of the ball.
module tb_ball_mover;

  localparam int W  = 16;
  localparam int BW = 4;
  localparam int TD = 2;
  localparam int C  = W / 2 - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    serve_dir = 2'b00;
  logic          pause = 1'b0;
  logic [1:0]    collide = 2'b00;
  logic [2*BW-1:0] pos;
  logic [1:0]    dir;
  logic          step;
  logic [3:0]    miss_side;
  logic          running;

  int n_cmp = 0;
  int n_err = 0;

  ball_mover #(.WIDTH(W), .BIT_OF_WIDTH(BW), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .serve_dir_i(serve_dir),
    .pause_i    (pause),
    .collide_i  (collide),
    .pos_o      (pos),
    .dir_o      (dir),
    .step_o     (step),
    .miss_side_o(miss_side),
    .running_o  (running)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = idle, 1 = run, 2 = score; coordinates as plain ints.
  int       m_mode = 0;
  int       m_x = C, m_y = C, m_cnt = 0;
  bit       m_dx = 1'b0, m_dy = 1'b0, m_step = 1'b0;
  bit [3:0] m_miss = 4'b0000;

  task automatic model_update();
    if (rst) begin
      m_mode = 0; m_x = C; m_y = C; m_cnt = 0;
      m_dx = 1'b0; m_dy = 1'b0; m_step = 1'b0; m_miss = 4'b0000;
      return;
    end
    m_step = 1'b0;
    case (m_mode)
      0: begin
        m_x = C; m_y = C; m_cnt = 0; m_miss = 4'b0000;
        if (start) begin
          m_dx = serve_dir[1]; m_dy = serve_dir[0]; m_mode = 1;
        end
      end
      1: begin
        if (!pause) begin
          if (m_cnt == TD - 1) begin
            m_cnt = 0;
            if (collide[0]) m_dx = !m_dx;
            if (collide[1]) m_dy = !m_dy;
            m_x = m_x + (m_dx ? 1 : -1);
            m_y = m_y + (m_dy ? 1 : -1);
            m_step = 1'b1;
            m_miss = {m_y == 0, m_y == W - 1, m_x == 0, m_x == W - 1};
            if (m_miss != 4'b0000) m_mode = 2;
          end else begin
            m_cnt++;
          end
        end
      end
      default: begin
        m_mode = 0; m_x = C; m_y = C; m_miss = 4'b0000;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; start = 1'b0; pause = 1'b0; collide = 2'b00;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic serve(input logic [1:0] d);
    serve_dir = d; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if ({pos, dir, running, step} !== {8'h77, 2'b00, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d: pos=%h dir=%b run=%b step=%b, expected 77/00/0/0",
                 i, pos, dir, running, step);
      end
    end
  endtask

  task automatic test_free_run();
    logic [7:0] prev, expd;
    do_reset(1);
    serve(2'b11);
    n_cmp++;
    if (running !== 1'b1 || pos !== 8'h77) begin
      n_err++;
      $display("FAIL serve_start: run=%b pos=%h, expected 1/77", running, pos);
    end
    prev = 8'h77;
    for (int k = 1; k <= 8; k++) begin
      for (int j = 0; j < TD - 1; j++) begin
        tick();
        n_cmp++;
        if (step !== 1'b0 || pos !== prev) begin
          n_err++;
          $display("FAIL free_run_hold k=%0d: step=%b pos=%h, expected 0/%h", k, step, pos, prev);
        end
      end
      tick();
      expd = 8'((C + k) * 17);
      n_cmp++;
      if (step !== 1'b1 || pos !== expd) begin
        n_err++;
        $display("FAIL free_run_step k=%0d: step=%b pos=%h, expected 1/%h", k, step, pos, expd);
      end
      n_cmp++;
      if (k == 8) begin
        if (miss_side !== 4'b0101 || running !== 1'b0) begin
          n_err++;
          $display("FAIL corner_score: miss=%b run=%b, expected 0101/0", miss_side, running);
        end
      end else if (miss_side !== 4'b0000 || running !== 1'b1) begin
        n_err++;
        $display("FAIL free_run_state k=%0d: miss=%b run=%b, expected 0000/1", k, miss_side, running);
      end
      prev = expd;
    end
    tick();
    n_cmp++;
    if ({pos, miss_side, running, step, dir} !== {8'h77, 4'b0000, 1'b0, 1'b0, 2'b11}) begin
      n_err++;
      $display("FAIL score_to_idle: pos=%h miss=%b run=%b step=%b dir=%b, expected 77/0000/0/0/11",
               pos, miss_side, running, step, dir);
    end
  endtask

  task automatic bounce_once(input logic [1:0] col, input logic [1:0] exp_dir,
                             input logic [7:0] exp_pos);
    do_reset(1);
    serve(2'b11);
    repeat (TD) tick();
    n_cmp++;
    if (pos !== 8'h88) begin
      n_err++;
      $display("FAIL bounce_setup col=%b: pos=%h, expected 88", col, pos);
    end
    repeat (TD - 1) tick();
    collide = col;
    tick();
    collide = 2'b00;
    n_cmp++;
    if (dir !== exp_dir || pos !== exp_pos || running !== 1'b1) begin
      n_err++;
      $display("FAIL bounce col=%b: dir=%b pos=%h run=%b, expected %b/%h/1",
               col, dir, pos, running, exp_dir, exp_pos);
    end
  endtask

  task automatic test_bounce();
    bounce_once(2'b01, 2'b01, 8'h79);
    bounce_once(2'b11, 2'b00, 8'h77);
  endtask

  task automatic test_pause();
    int n;
    do_reset(1);
    serve(2'b11);
    tick();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      collide = 2'b11;
      tick();
      n_cmp++;
      if (pos !== 8'h77 || step !== 1'b0 || dir !== 2'b11) begin
        n_err++;
        $display("FAIL pause_freeze i=%0d: pos=%h step=%b dir=%b, expected 77/0/11", i, pos, step, dir);
      end
    end
    pause = 1'b0;
    collide = 2'b00;
    n = 0;
    while (step !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_cmp++;
    if (1 + 5 + n != TD + 5 || pos !== 8'h88) begin
      n_err++;
      $display("FAIL pause_delay: step after %0d clocks pos=%h, expected %0d clocks pos=88",
               1 + 5 + n, pos, TD + 5);
    end
  endtask

  task automatic test_start_ignored_and_reset();
    int n;
    do_reset(1);
    serve(2'b11);
    tick();
    serve_dir = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (dir !== 2'b11 || running !== 1'b1) begin
      n_err++;
      $display("FAIL start_in_run: dir=%b run=%b, expected 11/1", dir, running);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (step !== 1'b1 && n < 40);
    n_cmp++;
    if (step !== 1'b1 || dir !== 2'b11) begin
      n_err++;
      $display("FAIL step_after_start: step=%b dir=%b, expected 1/11", step, dir);
    end
    repeat (TD - 1) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({pos, dir, running, step} !== {8'h77, 2'b00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_on_step: pos=%h dir=%b run=%b step=%b, expected 77/00/0/0",
               pos, dir, running, step);
    end
  endtask

  task automatic test_miss_left_top();
    do_reset(1);
    serve(2'b00);
    repeat (6 * TD) tick();
    n_cmp++;
    if (pos !== 8'h11 || running !== 1'b1) begin
      n_err++;
      $display("FAIL miss_approach: pos=%h run=%b, expected 11/1", pos, running);
    end
    repeat (TD) tick();
    n_cmp++;
    if ({pos, miss_side, running, step} !== {8'h00, 4'b1010, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL miss_left_top: pos=%h miss=%b run=%b step=%b, expected 00/1010/0/1",
               pos, miss_side, running, step);
    end
    tick();
    n_cmp++;
    if (pos !== 8'h77 || miss_side !== 4'b0000) begin
      n_err++;
      $display("FAIL miss_recentre: pos=%h miss=%b, expected 77/0000", pos, miss_side);
    end
  endtask

  task automatic test_random();
    logic [7:0] e_pos;
    do_reset(2);
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 3) == 0);
      serve_dir = 2'($urandom);
      pause     = ($urandom_range(0, 4) == 0);
      collide   = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
      tick();
      e_pos = {4'(m_x), 4'(m_y)};
      n_cmp++;
      if ({pos, dir, step, miss_side, running} !==
          {e_pos, m_dx, m_dy, m_step, m_miss, 1'(m_mode == 1)}) begin
        n_err++;
        $display("FAIL random cyc=%0d: pos=%h dir=%b step=%b miss=%b run=%b, expected %h/%b%b/%b/%b/%b",
                 i, pos, dir, step, miss_side, running, e_pos, m_dx, m_dy, m_step, m_miss, m_mode == 1);
      end
    end
    rst = 1'b0; start = 1'b0; pause = 1'b0; collide = 2'b00;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_bounce();
    test_pause();
    test_start_ignored_and_reset();
    test_miss_left_top();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
